regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port integer register file; next generation of the core's 2R1W register file.
- Adds configurable width, depth and port counts, optional write-to-read bypass, and a per-register busy scoreboard for the dual-issue pipeline.
- Sits between decode/issue (reads, allocation) and writeback (writes).

Parameters:
- XLEN, 32, data width per register.
- NREGS, 32, number of architectural registers (power of two, >=2).
- NUM_RD, 2, number of read ports.
- NUM_WR, 2, number of write ports.
- NUM_ALLOC, 2, number of scoreboard allocation ports.
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see stored value only.
- ZERO_REG, 1, 1 = register 0 hardwired to zero.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- rd_addr  in  NUM_RD x AW  read addresses (AW = clog2(NREGS)).
- rd_data  out  NUM_RD x XLEN  read data, combinational.
- rd_busy  out  NUM_RD  scoreboard busy for each read address, combinational.
- wr_en  in  NUM_WR  write enables.
- wr_addr  in  NUM_WR x AW  write addresses.
- wr_data  in  NUM_WR x XLEN  write data.
- alloc_en  in  NUM_ALLOC  mark destination register pending.
- alloc_addr  in  NUM_ALLOC x AW  destination register to mark pending.
- busy_vec  out  NREGS  registered scoreboard state, bit i = register i pending.

Behaviour:
- Reset:
  - rst sampled at posedge clears every register to 0 and busy_vec to 0.
  - rst has priority over same-cycle writes and allocs.
  - Reset mid-operation discards all in-flight pending state.
- Write:
  - Registered; data is visible in storage on the cycle after the wr_en edge.
  - Multiple write ports hitting the same address in one cycle: highest-index port wins.
- Read:
  - Combinational, zero latency.
  - BYPASS=1: if any wr_en[j] is set with wr_addr[j]==rd_addr[i], rd_data[i] = wr_data of the highest such j; otherwise rd_data[i] is the stored value.
  - BYPASS=0: always the stored value.
- Zero register (ZERO_REG=1):
  - Writes to address 0 are ignored.
  - Reads of address 0 return 0, including under bypass.
  - alloc to address 0 is ignored, so busy_vec[0] is always 0.
- Scoreboard:
  - Next busy[r] = 1 if any alloc_en targets r.
  - Otherwise 0 if any wr_en targets r.
  - Otherwise the current value is held.
  - Alloc and write to the same register in one cycle: alloc wins, because a new producer has been issued.
- rd_busy:
  - BYPASS=1: rd_busy[i] = busy_vec[rd_addr[i]] AND NOT (same-cycle write hits rd_addr[i]).
  - BYPASS=0: rd_busy[i] = busy_vec[rd_addr[i]].
- Arithmetic/width: addresses are exactly AW bits with no wrap logic needed; NREGS must equal 2^AW (elaboration assertion).
- No X propagation: all storage reset. Out-of-range parameters (NUM_RD=0, NUM_WR=0) are rejected by elaboration assertions.

Decomposition:
- Shared package regfile_pkg holds:
  - the AW derivation function;
  - the default XLEN/NREGS constants;
  - the reg_addr_t typedef for the default configuration.
- One sub-module, regfile_scoreboard:
  - owns busy_vec and the alloc/write priority rule;
  - parameterised by NREGS, NUM_WR, NUM_ALLOC and ZERO_REG.
- Storage, write priority and bypass muxing stay in regfile_mp.

Test Plan:
- Reset, then read all 32 addresses on both ports: all rd_data=0, busy_vec=0. Write r5=0xDEAD_BEEF, assert rst with wr_en on the same cycle: r5 reads 0.
- Port 0 and port 1 both write r7 (0x11, 0x22) in one cycle: next cycle r7 reads 0x22. With BYPASS=1, the same-cycle read of r7 returns 0x22.
- Write r0=0xFFFF_FFFF with ZERO_REG=1: read r0=0 same cycle and next cycle. alloc r0: busy_vec[0] stays 0.
- alloc r3 at cycle N: busy_vec[3]=1 at N+1. Write r3=0x1234 at N+3: rd_busy for r3 drops at N+3 (BYPASS=1) and busy_vec[3]=0 at N+4.
- Same cycle: alloc r9 and wr_en r9=0x55 while busy[9]=1: next cycle busy_vec[9]=1 and r9 stores 0x55.
- BYPASS=0 build: write r4=0xAA; the same-cycle read of r4 returns the old value 0, and the next-cycle read returns 0xAA.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
// The default configuration is 32 x 32-bit registers.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  // Address width for a given register count (at least one bit).
  function automatic int addr_width(input int nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

  localparam int AW_DEF = addr_width(NREGS_DEF);

  typedef logic [AW_DEF-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_mp_if.sv
// Read / write / allocate bundle between issue-writeback (master) and the
// register file (slave).
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int NREGS     = NREGS_DEF,
  parameter int NUM_RD    = 2,
  parameter int NUM_WR    = 2,
  parameter int NUM_ALLOC = 2
);
  localparam int AW = addr_width(NREGS);

  logic [NUM_RD-1:0][AW-1:0]    rd_addr;
  logic [NUM_RD-1:0][XLEN-1:0]  rd_data;
  logic [NUM_RD-1:0]            rd_busy;
  logic [NUM_WR-1:0]            wr_en;
  logic [NUM_WR-1:0][AW-1:0]    wr_addr;
  logic [NUM_WR-1:0][XLEN-1:0]  wr_data;
  logic [NUM_ALLOC-1:0]         alloc_en;
  logic [NUM_ALLOC-1:0][AW-1:0] alloc_addr;
  logic [NREGS-1:0]             busy_vec;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
    input  rd_data, rd_busy, busy_vec
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
    output rd_data, rd_busy, busy_vec
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits: allocation sets, writeback clears, allocation
// wins when both target the same register in one cycle.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS     = NREGS_DEF,
  parameter int NUM_WR    = 2,
  parameter int NUM_ALLOC = 2,
  parameter int ZERO_REG  = 1,
  localparam int AW       = addr_width(NREGS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_WR-1:0]            wr_en,
  input  logic [NUM_WR-1:0][AW-1:0]    wr_addr,
  input  logic [NUM_ALLOC-1:0]         alloc_en,
  input  logic [NUM_ALLOC-1:0][AW-1:0] alloc_addr,
  output logic [NREGS-1:0]             busy_vec
);

  logic [NREGS-1:0] busy_d, busy_q;

  // NOTE: combinational blocks use blocking '=' so later statements see the
  // earlier ones; here that ordering is what makes allocation override clear.
  always_comb begin
    busy_d = busy_q;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en[j]) busy_d[wr_addr[j]] = 1'b0;
    end
    for (int k = 0; k < NUM_ALLOC; k++) begin
      if (alloc_en[k]) busy_d[alloc_addr[k]] = 1'b1;
    end
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  // NOTE: state registers use non-blocking '<=' so every flop samples the
  // pre-edge value regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with optional write-to-read bypass,
// hardwired zero register and a busy scoreboard for the dual-issue pipeline.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int NREGS     = NREGS_DEF,
  parameter int NUM_RD    = 2,
  parameter int NUM_WR    = 2,
  parameter int NUM_ALLOC = 2,
  parameter int BYPASS    = 1,
  parameter int ZERO_REG  = 1
) (
  input  logic        clk,
  input  logic        rst,
  regfile_mp_if.slave bus
);

  localparam int AW = addr_width(NREGS);

  if (NREGS < 2 || (1 << AW) != NREGS) begin : g_bad_nregs
    $error("regfile_mp: NREGS must be a power of two >= 2");
  end
  if (NUM_RD < 1 || NUM_WR < 1 || NUM_ALLOC < 1) begin : g_bad_ports
    $error("regfile_mp: port counts must be at least 1");
  end

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];

  // Ascending port order lets the highest-index writer win on a collision.
  always_comb begin
    regs_d = regs_q;
    for (int j = 0; j < NUM_WR; j++) begin
      if (bus.wr_en[j] && !(ZERO_REG != 0 && bus.wr_addr[j] == '0))
        regs_d[bus.wr_addr[j]] = bus.wr_data[j];
    end
  end

  // NOTE: the array is reset explicitly so a read before the first write
  // returns 0 instead of X; this keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (rst) regs_q <= '{default: '0};
    else     regs_q <= regs_d;
  end

  regfile_scoreboard #(
    .NREGS     (NREGS),
    .NUM_WR    (NUM_WR),
    .NUM_ALLOC (NUM_ALLOC),
    .ZERO_REG  (ZERO_REG)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (bus.wr_en),
    .wr_addr    (bus.wr_addr),
    .alloc_en   (bus.alloc_en),
    .alloc_addr (bus.alloc_addr),
    .busy_vec   (bus.busy_vec)
  );

  logic [NUM_RD-1:0][XLEN-1:0] rd_data_c;
  logic [NUM_RD-1:0]           rd_hit_c;
  logic [NUM_RD-1:0]           rd_busy_c;

  // A same-cycle writeback both forwards its data and satisfies the pending bit.
  always_comb begin
    rd_data_c = '0;
    rd_hit_c  = '0;
    rd_busy_c = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_data_c[i] = regs_q[bus.rd_addr[i]];
      if (BYPASS != 0) begin
        for (int j = 0; j < NUM_WR; j++) begin
          if (bus.wr_en[j] && bus.wr_addr[j] == bus.rd_addr[i]) begin
            rd_hit_c[i]  = 1'b1;
            rd_data_c[i] = bus.wr_data[j];
          end
        end
      end
      if (ZERO_REG != 0 && bus.rd_addr[i] == '0) rd_data_c[i] = '0;
      rd_busy_c[i] = bus.busy_vec[bus.rd_addr[i]] & ~rd_hit_c[i];
    end
  end

  assign bus.rd_data = rd_data_c;
  assign bus.rd_busy = rd_busy_c;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one BYPASS=1 instance carries most of the
// checks, a second BYPASS=0 instance covers the stored-value-only read path.
module tb_regfile_mp;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  regfile_mp_if #(.XLEN(32), .NREGS(32), .NUM_RD(2), .NUM_WR(2), .NUM_ALLOC(2)) b0 ();
  regfile_mp_if #(.XLEN(32), .NREGS(32), .NUM_RD(2), .NUM_WR(2), .NUM_ALLOC(2)) b1 ();

  regfile_mp #(
    .XLEN(32), .NREGS(32), .NUM_RD(2), .NUM_WR(2), .NUM_ALLOC(2), .BYPASS(1), .ZERO_REG(1)
  ) dut_byp (
    .clk (clk),
    .rst (rst),
    .bus (b0)
  );

  regfile_mp #(
    .XLEN(32), .NREGS(32), .NUM_RD(2), .NUM_WR(2), .NUM_ALLOC(2), .BYPASS(0), .ZERO_REG(1)
  ) dut_nobyp (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    b0.rd_addr = '0; b0.wr_en = '0; b0.wr_addr = '0; b0.wr_data = '0;
    b0.alloc_en = '0; b0.alloc_addr = '0;
    b1.rd_addr = '0; b1.wr_en = '0; b1.wr_addr = '0; b1.wr_data = '0;
    b1.alloc_en = '0; b1.alloc_addr = '0;
  endtask

  // Commit the current inputs on the next rising edge, then settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;

    // Reset state: every address on both ports reads zero, nothing pending.
    check("reset_busy_vec", 64'(b0.busy_vec), 64'h0);
    for (int a = 0; a < 32; a++) begin
      b0.rd_addr[0] = 5'(a);
      b0.rd_addr[1] = 5'(31 - a);
      #1;
      check($sformatf("reset_rd0_r%0d", a), 64'(b0.rd_data[0]), 64'h0);
      check($sformatf("reset_rd1_r%0d", 31 - a), 64'(b0.rd_data[1]), 64'h0);
    end

    // Reset beats a same-cycle write.
    idle();
    b0.wr_en[0] = 1'b1; b0.wr_addr[0] = 5'd5; b0.wr_data[0] = 32'hDEAD_BEEF;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    b0.rd_addr[0] = 5'd5;
    #1;
    check("rst_over_write_r5", 64'(b0.rd_data[0]), 64'h0);

    // Two ports write r7: port 1 wins, visible through bypass and next cycle.
    idle();
    b0.wr_en = 2'b11;
    b0.wr_addr[0] = 5'd7; b0.wr_data[0] = 32'h11;
    b0.wr_addr[1] = 5'd7; b0.wr_data[1] = 32'h22;
    b0.rd_addr[0] = 5'd7;
    #1;
    check("collide_bypass_r7", 64'(b0.rd_data[0]), 64'h22);
    tick();
    idle();
    b0.rd_addr[0] = 5'd7;
    #1;
    check("collide_stored_r7", 64'(b0.rd_data[0]), 64'h22);

    // Zero register ignores writes (even under bypass) and allocation.
    idle();
    b0.wr_en[0] = 1'b1; b0.wr_addr[0] = 5'd0; b0.wr_data[0] = 32'hFFFF_FFFF;
    b0.alloc_en[0] = 1'b1; b0.alloc_addr[0] = 5'd0;
    b0.rd_addr[0] = 5'd0;
    #1;
    check("r0_same_cycle", 64'(b0.rd_data[0]), 64'h0);
    tick();
    idle();
    b0.rd_addr[0] = 5'd0;
    #1;
    check("r0_next_cycle", 64'(b0.rd_data[0]), 64'h0);
    check("r0_busy", 64'(b0.busy_vec[0]), 64'h0);

    // Allocate r3 at N, writeback at N+3.
    idle();
    b0.alloc_en[1] = 1'b1; b0.alloc_addr[1] = 5'd3;
    tick();                                   // N -> N+1
    idle();
    b0.rd_addr[0] = 5'd3; b0.rd_addr[1] = 5'd3;
    #1;
    check("alloc_r3_busy_vec", 64'(b0.busy_vec), 64'h0000_0008);
    check("alloc_r3_rd_busy0", 64'(b0.rd_busy[0]), 64'h1);
    check("alloc_r3_rd_busy1", 64'(b0.rd_busy[1]), 64'h1);
    tick();                                   // N+2
    tick();                                   // N+3
    b0.wr_en[1] = 1'b1; b0.wr_addr[1] = 5'd3; b0.wr_data[1] = 32'h1234;
    #1;
    check("wb_r3_rd_busy_drop", 64'(b0.rd_busy[0]), 64'h0);
    check("wb_r3_bypass_data", 64'(b0.rd_data[1]), 64'h1234);
    check("wb_r3_busy_vec_held", 64'(b0.busy_vec[3]), 64'h1);
    tick();                                   // N+4
    idle();
    b0.rd_addr[0] = 5'd3;
    #1;
    check("wb_r3_busy_vec_clear", 64'(b0.busy_vec[3]), 64'h0);
    check("wb_r3_stored", 64'(b0.rd_data[0]), 64'h1234);

    // Alloc and write to busy r9 together: alloc wins, data still stored.
    idle();
    b0.alloc_en[0] = 1'b1; b0.alloc_addr[0] = 5'd9;
    tick();
    idle();
    #1;
    check("r9_busy_before", 64'(b0.busy_vec[9]), 64'h1);
    b0.alloc_en[1] = 1'b1; b0.alloc_addr[1] = 5'd9;
    b0.wr_en[0] = 1'b1; b0.wr_addr[0] = 5'd9; b0.wr_data[0] = 32'h55;
    tick();
    idle();
    b0.rd_addr[0] = 5'd9;
    #1;
    check("r9_alloc_wins", 64'(b0.busy_vec[9]), 64'h1);
    check("r9_data", 64'(b0.rd_data[0]), 64'h55);
    check("r9_rd_busy", 64'(b0.rd_busy[0]), 64'h1);

    // BYPASS=0: same-cycle read sees the old value and the raw busy bit.
    idle();
    b1.alloc_en[0] = 1'b1; b1.alloc_addr[0] = 5'd4;
    tick();
    idle();
    b1.wr_en[0] = 1'b1; b1.wr_addr[0] = 5'd4; b1.wr_data[0] = 32'hAA;
    b1.rd_addr[0] = 5'd4;
    #1;
    check("nobyp_old_data", 64'(b1.rd_data[0]), 64'h0);
    check("nobyp_rd_busy", 64'(b1.rd_busy[0]), 64'h1);
    tick();
    idle();
    b1.rd_addr[0] = 5'd4;
    #1;
    check("nobyp_new_data", 64'(b1.rd_data[0]), 64'hAA);
    check("nobyp_busy_clear", 64'(b1.rd_busy[0]), 64'h0);

    // Mid-operation reset drops pending state and stored data.
    idle();
    b0.alloc_en[0] = 1'b1; b0.alloc_addr[0] = 5'd12;
    tick();
    idle();
    #1;
    check("r12_busy_pre_rst", 64'(b0.busy_vec), 64'h0000_1200);
    rst = 1'b1;
    b0.alloc_en[1] = 1'b1; b0.alloc_addr[1] = 5'd13;
    tick();
    rst = 1'b0;
    idle();
    b0.rd_addr[0] = 5'd7; b0.rd_addr[1] = 5'd9;
    #1;
    check("midrst_busy_vec", 64'(b0.busy_vec), 64'h0);
    check("midrst_r7", 64'(b0.rd_data[0]), 64'h0);
    check("midrst_r9", 64'(b0.rd_data[1]), 64'h0);
    b1.rd_addr[0] = 5'd4;
    #1;
    check("midrst_nobyp_r4", 64'(b1.rd_data[0]), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
